// File: rtl/reconfig_addsub_pipe.sv
// reconfig_addsub_pipe
// Two-stage pipelined add/subtract unit with operand-channel select,
// optional unsigned saturation and a valid/ready handshake with full
// backpressure. The WIDTH-bit carry chain is split at WIDTH/2: the lower
// half is summed before stage 1, the upper half before stage 2.
module reconfig_addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int SELW  = 2,
    parameter int TAGW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*WIDTH-1:0]  a_bus,
    input  logic [WIDTH-1:0]      b,
    input  logic [SELW-1:0]       sel,
    input  logic [1:0]            op,
    input  logic                  sat,
    input  logic [TAGW-1:0]       in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH:0]        y,
    output logic [TAGW-1:0]       out_tag
);

    localparam int LOW  = WIDTH / 2;
    localparam int HIGH = WIDTH - LOW;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,  // b + a
        OP_SUB  = 2'b01,  // b - a
        OP_RSUB = 2'b10,  // a - b
        OP_ONES = 2'b11   // b + ~a
    } op_e;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic v1, v2;
    logic adv1, adv2;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // ------------------------------------------------------------------
    // Operand select and operand conditioning
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;
    logic             cin;

    // Pick the addressed channel; out-of-range indices give zero.
    always_comb begin
        // NOTE: the default first means no path leaves a_sel unassigned, so no latch.
        a_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                a_sel = a_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Map the operation onto a single X + Y + cin adder.
    always_comb begin
        opx = b;
        opy = a_sel;
        cin = 1'b0;
        unique case (op_e'(op))
            OP_ADD:  begin opx = b;     opy = a_sel;  cin = 1'b0; end
            OP_SUB:  begin opx = b;     opy = ~a_sel; cin = 1'b1; end
            OP_RSUB: begin opx = a_sel; opy = ~b;     cin = 1'b1; end
            OP_ONES: begin opx = b;     opy = ~a_sel; cin = 1'b0; end
            default: begin opx = b;     opy = a_sel;  cin = 1'b0; end
        endcase
    end

    // Lower half of the carry chain, ahead of stage 1.
    logic [LOW:0] lo_full;
    assign lo_full = {1'b0, opx[LOW-1:0]} + {1'b0, opy[LOW-1:0]} + {{LOW{1'b0}}, cin};

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [LOW-1:0]  s1_sum_lo;
    logic            s1_c_lo;
    logic [HIGH-1:0] s1_x_hi;
    logic [HIGH-1:0] s1_y_hi;
    logic [1:0]      s1_op;
    logic            s1_sat;
    logic [TAGW-1:0] s1_tag;

    // Stage 1: capture lower sum/carry and the untouched upper operand halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            v1        <= 1'b0;
            s1_sum_lo <= '0;
            s1_c_lo   <= 1'b0;
            s1_x_hi   <= '0;
            s1_y_hi   <= '0;
            s1_op     <= '0;
            s1_sat    <= 1'b0;
            s1_tag    <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            // Payload only moves with a real transaction so bubbles do not toggle it.
            if (in_valid) begin
                s1_sum_lo <= lo_full[LOW-1:0];
                s1_c_lo   <= lo_full[LOW];
                s1_x_hi   <= opx[WIDTH-1:LOW];
                s1_y_hi   <= opy[WIDTH-1:LOW];
                s1_op     <= op;
                s1_sat    <= sat;
                s1_tag    <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Upper half of the carry chain and saturation, ahead of stage 2
    // ------------------------------------------------------------------
    logic [HIGH:0]    hi_full;
    logic             c_out;
    logic             is_sub;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_sum;

    assign hi_full = {1'b0, s1_x_hi} + {1'b0, s1_y_hi} + {{HIGH{1'b0}}, s1_c_lo};
    assign c_out   = hi_full[HIGH];
    assign raw_sum = {hi_full[HIGH-1:0], s1_sum_lo};
    // op 01 and 10 are the subtracting forms; their carry means "no borrow".
    assign is_sub  = s1_op[0] ^ s1_op[1];

    // Clamp on overflow (add forms) or borrow (subtract forms) when enabled.
    always_comb begin
        fin_sum = raw_sum;
        if (s1_sat) begin
            if (!is_sub && c_out) begin
                fin_sum = '1;
            end else if (is_sub && !c_out) begin
                fin_sum = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (module outputs)
    // ------------------------------------------------------------------

    // Stage 2: publish the result; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            y       <= '0;
            out_tag <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                y       <= {c_out, fin_sum};
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_reconfig_addsub_pipe.sv
// tb_reconfig_addsub_pipe
// Self-checking bench: an arithmetic reference model feeds an in-order
// expectation queue that a single monitor compares against the DUT on
// every cycle the output is valid. Directed cases pin the model to
// hand-computed results; a randomized phase exercises backpressure.
module tb_reconfig_addsub_pipe;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int SELW  = 2;
    localparam int TAGW  = 4;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] a_bus;
    logic [WIDTH-1:0]     b;
    logic [SELW-1:0]      sel;
    logic [1:0]           op;
    logic                 sat;
    logic [TAGW-1:0]      in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH:0]       y;
    logic [TAGW-1:0]      out_tag;

    reconfig_addsub_pipe #(
        .WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .TAGW(TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_bus     (a_bus),
        .b         (b),
        .sel       (sel),
        .op        (op),
        .sat       (sat),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain unsigned arithmetic.
    function automatic logic [WIDTH:0] model(input logic [NCH*WIDTH-1:0] bus,
                                             input logic [SELW-1:0] s,
                                             input logic [1:0] o,
                                             input logic st,
                                             input logic [WIDTH-1:0] bb);
        int unsigned mx, av, bv, r, sum;
        bit c;
        logic [WIDTH:0] res;
        mx = (1 << WIDTH) - 1;
        av = (int'(s) < NCH) ? int'(bus[s*WIDTH +: WIDTH]) : 0;
        bv = int'(bb);
        case (o)
            2'd0:    begin r = bv + av;        c = (r > mx); sum = r & mx;         end
            2'd1:    begin c = (bv >= av);     sum = (bv - av) & mx;               end
            2'd2:    begin c = (av >= bv);     sum = (av - bv) & mx;               end
            default: begin r = bv + (mx - av); c = (r > mx); sum = r & mx;         end
        endcase
        if (st) begin
            if ((o == 2'd0 || o == 2'd3) && c) sum = mx;
            if ((o == 2'd1 || o == 2'd2) && !c) sum = 0;
        end
        res = {c, sum[WIDTH-1:0]};
        return res;
    endfunction

    typedef struct packed {
        logic [WIDTH:0]  y;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: values seen at the falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready", {31'd0, in_ready},
                  {31'd0, !(exp_q.size() == 2 && !out_ready)});
            if (exp_q.size() == 2) check("no_bubble", {31'd0, out_valid}, 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("y", {23'd0, y}, {23'd0, exp_q[0].y});
                    check("out_tag", {28'd0, out_tag}, {28'd0, exp_q[0].tag});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{y: model(a_bus, sel, op, sat, b), tag: in_tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one transaction into an empty pipe and check it against a literal.
    task automatic run_one(input string name,
                           input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                           input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] bb,
                           input logic [SELW-1:0] s, input logic [1:0] o, input logic st,
                           input logic [TAGW-1:0] t, input logic [WIDTH:0] exp_y);
        int edges;
        a_bus = {a2, a1, a0};
        b = bb; sel = s; op = o; sat = st; in_tag = t;
        in_valid = 1'b1; out_ready = 1'b1;
        check({name, "_rdy"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 10) begin
            step();
            edges++;
        end
        check({name, "_lat"}, edges, 32'd2);
        check({name, "_y"}, {23'd0, y}, {23'd0, exp_y});
        check({name, "_tag"}, {28'd0, out_tag}, {28'd0, t});
        step();
    endtask

    function automatic logic [WIDTH-1:0] rnd_operand();
        int unsigned k;
        k = $urandom_range(0, 5);
        if (k == 0) return '0;
        if (k == 1) return '1;
        return WIDTH'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int next_tag, got, stall, saw_block, have_held;
        logic [WIDTH:0]  held_y;
        logic [TAGW-1:0] held_tag;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_bus = '0; b = '0; sel = '0; op = '0; sat = 1'b0; in_tag = '0;

        // Reset state
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {23'd0, y}, 32'd0);
        check("rst_tag", {28'd0, out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst = 1'b0;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Hand-computed expectations
        run_one("add",      8'hF0, 8'h00, 8'h00, 8'h20, 2'd0, 2'b00, 1'b0, 4'd1, 9'h110);
        run_one("sub",      8'h00, 8'h05, 8'h00, 8'h03, 2'd1, 2'b01, 1'b0, 4'd2, 9'h0FE);
        run_one("sub_sat",  8'h00, 8'h05, 8'h00, 8'h03, 2'd1, 2'b01, 1'b1, 4'd3, 9'h000);
        run_one("rsub",     8'h00, 8'h05, 8'h00, 8'h03, 2'd1, 2'b10, 1'b0, 4'd4, 9'h102);
        run_one("add_sat",  8'h00, 8'h00, 8'hFF, 8'h02, 2'd2, 2'b00, 1'b1, 4'd5, 9'h1FF);
        run_one("add_wrap", 8'h00, 8'h00, 8'hFF, 8'h02, 2'd2, 2'b00, 1'b0, 4'd6, 9'h101);
        run_one("oor_add",  8'h11, 8'h22, 8'h33, 8'h5A, 2'd3, 2'b00, 1'b0, 4'd7, 9'h05A);
        run_one("oor_ones", 8'h11, 8'h22, 8'h33, 8'h5A, 2'd3, 2'b11, 1'b0, 4'd8, 9'h159);
        run_one("oor_sub",  8'h11, 8'h22, 8'h33, 8'h5A, 2'd3, 2'b01, 1'b0, 4'd9, 9'h15A);

        // Backpressure: tags 1..5 back-to-back, 4-cycle stall after first output
        next_tag = 1; got = 0; stall = -1; saw_block = 0; have_held = 0;
        held_y = '0; held_tag = '0;
        in_valid = 1'b1; in_tag = 4'd1; out_ready = 1'b1;
        a_bus = {$urandom, $urandom}; b = rnd_operand(); sel = 2'($urandom); op = 2'($urandom); sat = 1'($urandom);
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    check("stall_y", {23'd0, y}, {23'd0, held_y});
                    check("stall_tag", {28'd0, out_tag}, {28'd0, held_tag});
                end
                held_y = y; held_tag = out_tag; have_held = 1;
            end else begin
                have_held = 0;
            end
            if (!in_ready) saw_block = 1;
            if (in_valid && in_ready) next_tag++;
            if (out_valid && out_ready) begin
                check("bp_order", {28'd0, out_tag}, got + 1);
                got++;
            end
            if (out_valid && stall < 0) stall = 4;
            step();
            out_ready = (stall <= 0);
            if (stall > 0) stall--;
            in_valid = (next_tag <= 5);
            in_tag = TAGW'(next_tag);
            a_bus = {$urandom, $urandom}; b = rnd_operand(); sel = 2'($urandom); op = 2'($urandom); sat = 1'($urandom);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", got, 32'd5);
        check("bp_in_ready_dropped", saw_block, 32'd1);
        step();

        // Asynchronous reset with two transactions in flight
        a_bus = {8'h00, 8'h00, 8'h10}; b = 8'h01; sel = 2'd0; op = 2'b00; sat = 1'b0;
        in_valid = 1'b1; in_tag = 4'd7;
        step();
        in_tag = 4'd8;
        step();
        in_valid = 1'b0;
        check("pre_rst_full", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_y", {23'd0, y}, 32'd0);
        check("async_rst_tag", {28'd0, out_tag}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        run_one("after_rst", 8'h01, 8'h00, 8'h00, 8'h01, 2'd0, 2'b00, 1'b0, 4'd10, 9'h002);

        // Randomized traffic with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a_bus  = {rnd_operand(), rnd_operand(), rnd_operand()};
            b      = rnd_operand();
            sel    = 2'($urandom);
            op     = 2'($urandom);
            sat    = 1'($urandom);
            in_tag = 4'($urandom);
            step();
        end

        // Drain
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        step();
        check("drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
